// File: rtl/bitserial_adder_ctrl.sv
// Bit-serial add/sub sequencer driving an external 1-bit full-adder cell, LSB first.
// Optional subtract mode is enabled by defining BITSERIAL_SUB_EN (adds port in_sub).
module bitserial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef BITSERIAL_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             add_a,
  output logic             add_b,
  output logic             add_cin,
  input  logic             add_sum,
  input  logic             add_cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] b_load;
  logic             cin_load;

  // Subtraction is a + ~b + 1, so only the loaded B operand and initial carry change.
  always_comb begin
`ifdef BITSERIAL_SUB_EN
    b_load   = in_sub ? ~in_b : in_b;
    cin_load = in_sub ? 1'b1 : in_cin;
`else
    b_load   = in_b;
    cin_load = in_cin;
`endif
  end

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_sr_d  = in_a;
          b_sr_d  = b_load;
          carry_d = cin_load;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // New sum bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts.
        sum_sr_d = (sum_sr_q >> 1) | (WIDTH'(add_sum) << (WIDTH - 1));
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        carry_d  = add_cout;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand and sum shift registers need no reset: they are only observed in RUN/DONE.
  always_ff @(posedge clk) begin
    a_sr_q   <= a_sr_d;
    b_sr_q   <= b_sr_d;
    sum_sr_q <= sum_sr_d;
  end

  logic run;
  assign run       = (state_q == S_RUN);
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_sum   = out_valid ? sum_sr_q : '0;
  assign out_cout  = out_valid & carry_q;
  assign add_a     = run & a_sr_q[0];
  assign add_b     = run & b_sr_q[0];
  assign add_cin   = run & carry_q;

endmodule

// File: tb/tb_bitserial_adder_ctrl.sv
// Randomized self-checking bench for bitserial_adder_ctrl; models the full-adder cell
// and checks every result against plain integer arithmetic.
module tb_bitserial_adder_ctrl;
  localparam int WIDTH = 8;
  localparam logic [63:0] MASK = (WIDTH >= 64) ? '1 : ((64'd1 << WIDTH) - 64'd1);

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             add_a;
  logic             add_b;
  logic             add_cin;
  logic             add_sum;
  logic             add_cout;

  int checks;
  int failures;
  logic [63:0] hold_a, hold_b;
  logic        hold_cin, hold_sub;

  bitserial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
`ifdef BITSERIAL_SUB_EN
    .in_sub   (in_sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  // External combinational full-adder cell
  assign add_sum  = add_a ^ add_b ^ add_cin;
  assign add_cout = (add_a & add_b) | (add_a & add_cin) | (add_b & add_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain modular arithmetic; subtract reports cout=1 when no borrow.
  function automatic logic [64:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic cin, input logic sub);
    logic [63:0] s;
    logic        c;
    if (sub) begin
      s = (a - b) & MASK;
      c = (a >= b);
    end else begin
      s = (a + b + 64'(cin)) & MASK;
      c = ((a + b + 64'(cin)) >> WIDTH) != 0;
    end
    return {c, s};
  endfunction

  task automatic start(input logic [63:0] a, input logic [63:0] b, input logic cin,
                       input logic sub);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    chk("in_ready_wait", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_a     = a[WIDTH-1:0];
    in_b     = b[WIDTH-1:0];
    in_cin   = cin;
    in_sub   = sub;
    tick();
    in_valid = 1'b0;
    in_a     = WIDTH'($urandom);
    in_b     = WIDTH'($urandom);
    in_cin   = 1'($urandom);
  endtask

  // Call right after the accepting edge. keep=1 presents hold_* operands during the wait.
  task automatic finish_op(input logic [63:0] a, input logic [63:0] b, input logic cin,
                           input logic sub, input int hold, input bit keep);
    logic [64:0] r;
    logic [63:0] beff, pm, carry_in;
    logic        ceff;
    int lat;
    r    = model(a, b, cin, sub);
    beff = sub ? (~b & MASK) : b;
    ceff = sub ? 1'b1 : cin;
    lat  = 0;
    while (!out_valid && lat < WIDTH + 20) begin
      if (lat < WIDTH) begin
        pm       = (64'd1 << lat) - 64'd1;
        carry_in = ((a & pm) + (beff & pm) + 64'(ceff)) >> lat;
        chk("add_a", 64'(add_a), 64'(a[lat]));
        chk("add_b", 64'(add_b), 64'(beff[lat]));
        chk("add_cin", 64'(add_cin), carry_in & 64'd1);
        chk("out_valid_run", 64'(out_valid), 64'd0);
      end
      tick();
      lat++;
    end
    chk("latency", 64'(lat), 64'(WIDTH));
    if (keep) begin
      in_valid = 1'b1;
      in_a     = hold_a[WIDTH-1:0];
      in_b     = hold_b[WIDTH-1:0];
      in_cin   = hold_cin;
      in_sub   = hold_sub;
    end
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_sum", 64'(out_sum), r[63:0]);
      chk("hold_cout", 64'(out_cout), 64'(r[64]));
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_add", {61'd0, add_a, add_b, add_cin}, 64'd0);
      tick();
    end
    out_ready = 1'b1;
    chk("out_valid", 64'(out_valid), 64'd1);
    chk("sum", 64'(out_sum), r[63:0]);
    chk("cout", 64'(out_cout), 64'(r[64]));
    chk("done_add", {61'd0, add_a, add_b, add_cin}, 64'd0);
    tick();
    out_ready = 1'b0;
    chk("post_valid", 64'(out_valid), 64'd0);
    chk("post_in_ready", 64'(in_ready), 64'd1);
    chk("post_sum", 64'(out_sum), 64'd0);
  endtask

  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic cin,
                       input logic sub, input int hold);
    start(a, b, cin, sub);
    finish_op(a, b, cin, sub, hold, 1'b0);
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_sum"}, 64'(out_sum), 64'd0);
    chk({tag, "_out_cout"}, 64'(out_cout), 64'd0);
    chk({tag, "_add"}, {61'd0, add_a, add_b, add_cin}, 64'd0);
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic        rc, rs, sub_en;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b0;
`ifdef BITSERIAL_SUB_EN
    sub_en = 1'b1;
`else
    sub_en = 1'b0;
`endif
    tick();
    tick();
    rst_n = 1'b1;
    check_idle_zero("reset");

    do_op(64'h5A & MASK, 64'h33 & MASK, 1'b0, 1'b0, 0);
    do_op(64'hFF & MASK, 64'h01 & MASK, 1'b0, 1'b0, 1);
    do_op(64'hFF & MASK, 64'hFF & MASK, 1'b1, 1'b0, 0);

    // Backpressure in DONE with a competing request; accept follows the handshake by one cycle
    hold_a   = 64'hC3 & MASK;
    hold_b   = 64'h5E & MASK;
    hold_cin = 1'b1;
    hold_sub = 1'b0;
    start(64'h12 & MASK, 64'h34 & MASK, 1'b0, 1'b0);
    finish_op(64'h12 & MASK, 64'h34 & MASK, 1'b0, 1'b0, 5, 1'b1);
    tick();
    chk("late_accept", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    finish_op(hold_a, hold_b, hold_cin, hold_sub, 0, 1'b0);

    // Reset in the middle of a RUN
    start(64'h0F & MASK, 64'h01 & MASK, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_idle_zero("midrun_reset");
    do_op(64'h01 & MASK, 64'h01 & MASK, 1'b0, 1'b0, 0);

    // Reset while a result is waiting in DONE
    start(64'hAA & MASK, 64'h55 & MASK, 1'b1, 1'b0);
    for (int i = 0; i < WIDTH + 1; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_idle_zero("done_reset");

`ifdef BITSERIAL_SUB_EN
    do_op(64'h10 & MASK, 64'h01 & MASK, 1'b0, 1'b1, 0);
    do_op(64'h00, 64'h01 & MASK, 1'b1, 1'b1, 0);
`endif

    for (int n = 0; n < 40; n++) begin
      ra = {$urandom, $urandom} & MASK;
      rb = {$urandom, $urandom} & MASK;
      rc = 1'($urandom);
      rs = sub_en & 1'($urandom);
      do_op(ra, rb, rc, rs, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
